// File: rtl/mult_pkg.sv
// Shared constants and FSM state encoding for the sequential multiplier.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_ITER  = MULT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mult32_ctrl.sv
// Control FSM and iteration counter for the shift-add multiplier.
module mult32_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned ITER = MULT_ITER
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic load,
    output logic step,
    output logic busy,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(ITER) + 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    // State, counter and registered status flags; unused encoding falls back to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath strobes: load only on the accepting edge, step every RUN cycle.
    assign load = (state_q == S_IDLE) && start;
    assign step = (state_q == S_RUN);
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned shift-add multiplier producing a 2*WIDTH-bit hi/lo product.
module mult32_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic               load;
    logic               step;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mcand_d;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     sum_c;

    mult32_ctrl #(
        .ITER (WIDTH)
    ) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .load  (load),
        .step  (step),
        .busy  (busy),
        .done  (done)
    );

    // One partial-product add per step; the carry becomes the MSB after the shift.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        sum_c   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
        if (load) begin
            mcand_d = a;
            prod_d  = {WIDTH'(0), b};
        end else if (step) begin
            prod_d  = {sum_c, prod_q[WIDTH-1:1]};
        end
    end

    // Operand and working-product registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign hi = prod_q[2*WIDTH-1:WIDTH];
    assign lo = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_mult32_seq.sv
// Directed and randomized checks of mult32_seq against a plain-arithmetic product model.
module tb_mult32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult32_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one multiply, verify busy, latency, result, done width and hold in IDLE.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input string tag);
        int n;
        logic [63:0] exp;
        exp = model(av, bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_product"}, {hi, lo}, exp);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_fall"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_held"}, {hi, lo}, exp);
    endtask

    // Count done pulses seen over a number of cycles.
    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int n;
        int dcnt;
        int t;
        int last_t;
        logic [31:0] ca;
        logic [31:0] cb;

        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
        reset = 1'b0;

        run_op(32'd3, 32'd5, "small");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
        chk("max_literal", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h1234_5678, 32'd0, "zero_b");
        run_op(32'h8000_0000, 32'd2, "msb_a");
        chk("msb_literal", {hi, lo}, 64'h0000_0001_0000_0000);

        // Start pulses during RUN and DONE must be ignored.
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h0000_1234; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 11;
        while (!done && n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
        chk("ign_latency", 64'(n), 64'd32);
        chk("ign_product", {hi, lo}, model(32'hDEAD_BEEF, 32'h0000_1234));
        a = 32'd11; b = 32'd13; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("ign_done_idle", {62'd0, busy, done}, 64'd0);
        chk("ign_held", {hi, lo}, model(32'hDEAD_BEEF, 32'h0000_1234));
        count_done(40, dcnt);
        chk("ign_no_second_op", 64'(dcnt), 64'd0);
        run_op(32'd11, 32'd13, "after_ignore");

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a = 32'hCAFE_F00D; b = 32'h7777_7777; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) begin @(posedge clk); @(negedge clk); end
        #1 reset = 1'b1;
        #1;
        chk("abort_outputs", {30'd0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(40, dcnt);
        chk("abort_no_done", 64'(dcnt), 64'd0);
        run_op(32'd7, 32'd6, "after_abort");
        chk("after_abort_lo", 64'(lo), 64'h2A);

        // Randomized operands.
        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom, $sformatf("rand%0d", i));
        end

        // Back-to-back with start held high; new operands loaded in each DONE cycle.
        @(negedge clk);
        ca = $urandom; cb = $urandom;
        a = ca; b = cb; start = 1'b1;
        t = 0; last_t = -2;
        for (int op = 0; op < 4; op++) begin
            n = 0;
            do begin
                @(posedge clk); t++; n++;
                @(negedge clk);
            end while (!done && n < 100);
            if (op == 0) chk("b2b_first_latency", 64'(t), 64'd33);
            else         chk($sformatf("b2b_interval%0d", op), 64'(t - last_t), 64'd34);
            chk($sformatf("b2b_product%0d", op), {hi, lo}, model(ca, cb));
            last_t = t;
            ca = $urandom; cb = $urandom;
            a = ca; b = cb;
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_final_idle", {62'd0, busy, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult32_seq.md
# mult32_seq

Sequential unsigned shift-add multiplier with its own control FSM, used by the 32-bit MIPS datapath to execute MULTU. It accepts two WIDTH-bit operands on a start pulse and iterates one partial product per clock over the shared adder. It then presents the 2·WIDTH-bit product as hi/lo words for the HI/LO register write. The CPU control unit stalls on `busy` and writes HI/LO on `done`.

## Interface

- `WIDTH`, default 32: operand width; product is 2·WIDTH bits.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high. Forces IDLE and clears all registers.
- `start` input 1: request a multiply. Sampled only in IDLE.
- `a` input WIDTH: multiplicand. Captured on the accepting edge.
- `b` input WIDTH: multiplier. Captured on the accepting edge.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: single-cycle pulse; high only in DONE.
- `hi` output WIDTH: upper half of the working product register.
- `lo` output WIDTH: lower half of the working product register.

## Operation

- Registers:
  - `mcand` (WIDTH): captured multiplicand.
  - `prod` (2·WIDTH): working product; `hi` = `prod[2W-1:W]`, `lo` = `prod[W-1:0]`.
  - `cnt` (clog2(WIDTH)+1 bits): iteration counter.
  - `state` (2 bits).
- States: IDLE, RUN, DONE. The fourth encoding is illegal and recovers to IDLE on the next edge.
- IDLE:
  - With `start`=1 at an edge: `mcand`←`a`, `prod`←{0, `b`}, `cnt`←0, go to RUN.
  - Otherwise hold all registers.
- RUN, each edge:
  - sum = {0, `prod` upper half} + (`prod[0]` ? {0, `mcand`} : 0), computed at WIDTH+1 bits.
  - `prod`←{sum, `prod[W-1:1]`}, a right shift with the carry kept.
  - `cnt`←`cnt`+1.
  - On the edge where `cnt` = WIDTH-1, go to DONE.
- DONE:
  - `done`=1 and `prod` holds the final product.
  - Next edge goes unconditionally to IDLE; `prod` is held.
- `start` in RUN or DONE is ignored. There is no queuing and no error flag.
- Result validity: `hi`/`lo` are valid from the DONE cycle until the next accepted start. During RUN they show intermediate values.
- Arithmetic:
  - Unsigned only. Carry out of the WIDTH-bit add is never lost; it becomes the MSB after the shift.
  - No overflow is possible, since the product fits in 2·WIDTH bits.
- Reset:
  - Reset outputs: `busy`=0, `done`=0, `hi`=0, `lo`=0, `state`=IDLE.
  - Reset asserted mid-RUN or in DONE aborts immediately (asynchronously). No `done` is produced for the aborted operation.

## Timing

- Start accepted at edge k:
  - Edges k+1 … k+WIDTH perform the WIDTH iterations.
  - State is DONE after edge k+WIDTH, so `done` is high in that one cycle.
  - IDLE follows after edge k+WIDTH+1.
- Latency: WIDTH cycles from the accepting edge to `done` (32 cycles at default).
- Busy: `busy` rises in the cycle after the accepting edge and stays high for WIDTH+1 cycles.
- Throughput: the earliest next accept is edge k+WIDTH+2, so one multiply per WIDTH+2 cycles.
- Outputs are registered or decoded from `state` only. There is no combinational path from `start`, `a` or `b` to any output.

## Structure

- Shared package `mult_pkg`:
  - State encodings S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10.
  - Iteration constant MULT_ITER = WIDTH.
- Sub-module `mult32_ctrl` holds the FSM and counter:
  - Inputs `clk`, `reset`, `start`.
  - Outputs `load`, `step`, `busy`, `done`.
- The top level instantiates `mult32_ctrl` plus the `mcand`/`prod` registers and the WIDTH+1-bit adder.
- No other sub-modules.

## Test plan

1. Small product: reset, then `a`=3, `b`=5, `start` for one cycle. Expect `busy` on the next cycle and `done` exactly 32 cycles after the accepting edge, with `hi`=0x00000000, `lo`=0x0000000F. Expect `done` low one cycle later and `hi`/`lo` held in IDLE.
2. Maximum product (carry propagation): `a`=`b`=0xFFFFFFFF. Expect `hi`=0xFFFFFFFE, `lo`=0x00000001 at `done`.
3. Zero multiplier: `a`=0x12345678, `b`=0. Expect `hi`=`lo`=0 with the same 32-cycle latency. Then `a`=0x80000000, `b`=2: expect `hi`=0x00000001, `lo`=0.
4. Start ignored while busy: pulse `start` with new operands 10 cycles into a multiply and again during DONE. Expect the original result, a single `done` pulse, and no second operation. Then `start` in IDLE is accepted on that edge.
5. Reset mid-operation: assert `reset` asynchronously (between clock edges) 15 cycles into RUN. Expect `busy`, `done`, `hi` and `lo` to go to 0 immediately and no `done` after release. A subsequent 7×6 gives `lo`=0x0000002A.
6. Back-to-back operations: hold `start` high continuously. Expect accepts every 34 cycles, one `done` pulse per operation, and correct results each time.
